// File: rtl/wb_port_splitter.sv
// wb_port_splitter: Wishbone classic single-master to NUM_PORTS-slave splitter.
// The request is registered into a one-hot port select, and the response data is registered.
// A watchdog bounds every downstream access. Unmapped ports return an error. A master abort
// (wb_cyc_i low) cancels the transaction quietly.
// Ports: wb_clk_i/wb_rst_i (sync, active-high); upstream wb_cyc/stb/we/adr/dat/sel in,
//        wb_ack/err/rty/dat out; downstream wbvec_* buses, port p at slice p of each vector.
// Optional macro WB_SPLITTER_TIMEOUT_LOG_EN adds timeout_count_o and last_timeout_adr_o.
module wb_port_splitter #(
  parameter int NUM_PORTS = 8,
  parameter int ADR_WIDTH = 12,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_LSB   = 6,
  parameter int SEL_BITS  = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             wb_cyc_i,
  input  logic                             wb_stb_i,
  input  logic                             wb_we_i,
  input  logic [ADR_WIDTH-1:0]             wb_adr_i,
  input  logic [DAT_WIDTH-1:0]             wb_dat_i,
  input  logic [DAT_WIDTH/8-1:0]           wb_sel_i,
  output logic                             wb_ack_o,
  output logic                             wb_err_o,
  output logic                             wb_rty_o,
  output logic [DAT_WIDTH-1:0]             wb_dat_o,
  output logic [NUM_PORTS-1:0]             wbvec_cyc_o,
  output logic [NUM_PORTS-1:0]             wbvec_stb_o,
  output logic [NUM_PORTS-1:0]             wbvec_we_o,
  output logic [NUM_PORTS*ADR_WIDTH-1:0]   wbvec_adr_o,
  output logic [NUM_PORTS*DAT_WIDTH-1:0]   wbvec_dat_o,
  output logic [NUM_PORTS*DAT_WIDTH/8-1:0] wbvec_sel_o,
  input  logic [NUM_PORTS-1:0]             wbvec_ack_i,
  input  logic [NUM_PORTS-1:0]             wbvec_err_i,
  input  logic [NUM_PORTS*DAT_WIDTH-1:0]   wbvec_dat_i
`ifdef WB_SPLITTER_TIMEOUT_LOG_EN
  ,
  output logic [15:0]                      timeout_count_o,
  output logic [ADR_WIDTH-1:0]             last_timeout_adr_o
`endif
);

  localparam int SEL_W = DAT_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   port_q, port_d;    // one-hot; doubles as downstream cyc/stb
  logic [ADR_WIDTH-1:0]   adr_q;
  logic [DAT_WIDTH-1:0]   dat_q;
  logic [SEL_W-1:0]       sel_q;
  logic                   we_q;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   err_pend_q, err_pend_d;
  logic [DAT_WIDTH-1:0]   rdat_q;
  logic                   latch_req;
  logic                   cap_dat;

  logic [SEL_BITS-1:0]    sel_field;
  logic [NUM_PORTS-1:0]   req_oh;
  logic                   req_mapped;
  logic                   sel_ack;
  logic                   sel_err;
  logic [DAT_WIDTH-1:0]   sel_rdat;

`ifdef WB_SPLITTER_TIMEOUT_LOG_EN
  logic                   to_evt;
  logic [15:0]            to_cnt_q;
  logic [ADR_WIDTH-1:0]   to_adr_q;
`endif

  assign sel_field = wb_adr_i[SEL_LSB +: SEL_BITS];
  assign req_mapped = (int'(sel_field) < NUM_PORTS);

  always_comb begin
    req_oh = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_oh[p] = (int'(sel_field) == p);
    end
  end

  // Masking with the one-hot select is what makes strays from other ports harmless.
  assign sel_ack = |(wbvec_ack_i & port_q);
  assign sel_err = |(wbvec_err_i & port_q);

  always_comb begin
    sel_rdat = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_q[p]) sel_rdat = wbvec_dat_i[p*DAT_WIDTH +: DAT_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    port_d     = port_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    err_pend_d = err_pend_q;
    latch_req  = 1'b0;
    cap_dat    = 1'b0;
`ifdef WB_SPLITTER_TIMEOUT_LOG_EN
    to_evt     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        err_pend_d = 1'b0;
        if (wb_cyc_i && wb_stb_i) begin
          latch_req = 1'b1;
          if (req_mapped) begin
            port_d  = req_oh;
            state_d = ACTIVE;
          end else begin
            err_pend_d = 1'b1;
            state_d    = RESP;
          end
        end
      end
      ACTIVE: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (!wb_cyc_i) begin
          port_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sel_ack || sel_err) begin
          port_d  = '0;
          cap_dat = 1'b1;
          err_d   = sel_err;
          ack_d   = !sel_err;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          // This is the TIMEOUT-th cycle with the downstream strobe up.
          port_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
`ifdef WB_SPLITTER_TIMEOUT_LOG_EN
          to_evt  = 1'b1;
`endif
        end
      end
      RESP: begin
        if (!wb_cyc_i) begin
          err_pend_d = 1'b0;
          cnt_d      = '0;
          state_d    = IDLE;
        end else if (err_pend_q) begin
          // Unmapped access: the error is issued one cycle into RESP to keep the
          // minimum upstream latency at two cycles.
          err_d      = 1'b1;
          err_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        port_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      port_q     <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
      rdat_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      port_q     <= port_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
      if (latch_req) begin
        adr_q <= wb_adr_i;
        dat_q <= wb_dat_i;
        sel_q <= wb_sel_i;
        we_q  <= wb_we_i;
      end
      if (cap_dat) rdat_q <= sel_rdat;
    end
  end

`ifdef WB_SPLITTER_TIMEOUT_LOG_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_cnt_q <= '0;
      to_adr_q <= '0;
    end else if (to_evt) begin
      if (to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
      to_adr_q <= adr_q;
    end
  end

  assign timeout_count_o    = to_cnt_q;
  assign last_timeout_adr_o = to_adr_q;
`endif

  // Gating by wb_cyc_i hides a registered response from a master that has already aborted.
  assign wb_ack_o = ack_q & wb_cyc_i;
  assign wb_err_o = err_q & wb_cyc_i;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = rdat_q;

  assign wbvec_cyc_o = port_q;
  assign wbvec_stb_o = port_q;
  assign wbvec_we_o  = {NUM_PORTS{we_q}};
  assign wbvec_adr_o = {NUM_PORTS{adr_q}};
  assign wbvec_dat_o = {NUM_PORTS{dat_q}};
  assign wbvec_sel_o = {NUM_PORTS{sel_q}};

endmodule

// File: tb/tb_wb_port_splitter.sv
module tb_wb_port_splitter;
  localparam int NP = 6;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [AW-1:0]   adr = '0;
  logic [DW-1:0]   wdat = '0;
  logic [SW-1:0]   sel = '0;
  logic            ack_o, err_o, rty_o;
  logic [DW-1:0]   dat_o;
  logic [NP-1:0]   vcyc, vstb, vwe;
  logic [NP*AW-1:0] vadr;
  logic [NP*DW-1:0] vdat_o;
  logic [NP*SW-1:0] vsel;
  logic [NP-1:0]   vack = '0, verr = '0;
  logic [NP*DW-1:0] vdat_i = '0;
`ifdef WB_SPLITTER_TIMEOUT_LOG_EN
  logic [15:0]     to_cnt;
  logic [AW-1:0]   to_adr;
`endif

  int n_checks = 0;
  int n_fail = 0;

  wb_port_splitter #(.NUM_PORTS(NP), .ADR_WIDTH(AW), .DAT_WIDTH(DW),
                     .SEL_LSB(6), .SEL_BITS(3), .TIMEOUT(255)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_ack_o(ack_o), .wb_err_o(err_o), .wb_rty_o(rty_o), .wb_dat_o(dat_o),
    .wbvec_cyc_o(vcyc), .wbvec_stb_o(vstb), .wbvec_we_o(vwe),
    .wbvec_adr_o(vadr), .wbvec_dat_o(vdat_o), .wbvec_sel_o(vsel),
    .wbvec_ack_i(vack), .wbvec_err_i(verr), .wbvec_dat_i(vdat_i)
`ifdef WB_SPLITTER_TIMEOUT_LOG_EN
    , .timeout_count_o(to_cnt), .last_timeout_adr_o(to_adr)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
  endtask

  task automatic drop();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++; if ({ack_o, err_o, rty_o} !== 3'b000) begin n_fail++; $display("FAIL reset_resp: got %b expected 000", {ack_o, err_o, rty_o}); end
    n_checks++; if (dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 0", dat_o); end
    n_checks++; if ({vcyc, vstb, vwe} !== '0) begin n_fail++; $display("FAIL reset_vec_ctl: got %h expected 0", {vcyc, vstb, vwe}); end
    n_checks++; if ({vadr, vdat_o, vsel} !== '0) begin n_fail++; $display("FAIL reset_vec_bus: nonzero, expected 0"); end
`ifdef WB_SPLITTER_TIMEOUT_LOG_EN
    n_checks++; if ({to_cnt, to_adr} !== '0) begin n_fail++; $display("FAIL reset_tolog: got %h/%h expected 0", to_cnt, to_adr); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_read_port3();
    req(12'h0C4, 1'b0, 32'h0);
    step();                                   // cycle 1
    n_checks++; if (vstb !== 6'b001000 || vcyc !== 6'b001000) begin n_fail++; $display("FAIL read_stb: got %b/%b expected 001000", vcyc, vstb); end
    n_checks++; if (vadr[3*AW +: AW] !== 12'h0C4) begin n_fail++; $display("FAIL read_adr: got %h expected 0c4", vadr[3*AW +: AW]); end
    step();                                   // cycle 2
    n_checks++; if (ack_o !== 1'b0 || vstb !== 6'b001000) begin n_fail++; $display("FAIL read_wait: ack %b stb %b expected 0/001000", ack_o, vstb); end
    step();                                   // cycle 3: slave acks
    vack[3] = 1'b1; vdat_i[3*DW +: DW] = 32'hDEADBEEF;
    step();                                   // cycle 4
    n_checks++; if (ack_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL read_ack: got ack %b err %b expected 1/0", ack_o, err_o); end
    n_checks++; if (dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_dat: got %h expected deadbeef", dat_o); end
    n_checks++; if (vstb !== 6'b0) begin n_fail++; $display("FAIL read_stb_drop: got %b expected 0", vstb); end
    vack = '0; drop();
    step();
    n_checks++; if (ack_o !== 1'b0 || dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_after: ack %b dat %h expected 0/deadbeef", ack_o, dat_o); end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    req(12'h140, 1'b0, 32'h0);
    for (int c = 1; c <= 255; c++) begin
      step();
      if (vstb !== 6'b100000 || err_o !== 1'b0 || ack_o !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL timeout_hold: got %0d bad cycles expected 0", bad); end
    step();                                   // cycle 256
    n_checks++; if (err_o !== 1'b1 || ack_o !== 1'b0) begin n_fail++; $display("FAIL timeout_err: got err %b ack %b expected 1/0", err_o, ack_o); end
    n_checks++; if (vstb !== 6'b0) begin n_fail++; $display("FAIL timeout_stb: got %b expected 0", vstb); end
    n_checks++; if (dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL timeout_dat_hold: got %h expected deadbeef", dat_o); end
`ifdef WB_SPLITTER_TIMEOUT_LOG_EN
    n_checks++; if (to_cnt !== 16'd1 || to_adr !== 12'h140) begin n_fail++; $display("FAIL timeout_log: got %0d/%h expected 1/140", to_cnt, to_adr); end
`endif
    drop();
    step();
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse: got %b expected 0", err_o); end
  endtask

  task automatic test_write();
    req(12'h040, 1'b1, 32'h12345678);
    step();                                   // cycle 1
    n_checks++; if (vstb !== 6'b000010) begin n_fail++; $display("FAIL write_stb: got %b expected 000010", vstb); end
    n_checks++; if (vwe[1] !== 1'b1 || vdat_o[1*DW +: DW] !== 32'h12345678 || vsel[1*SW +: SW] !== 4'hF) begin n_fail++; $display("FAIL write_bus: we %b dat %h sel %h expected 1/12345678/f", vwe[1], vdat_o[1*DW +: DW], vsel[1*SW +: SW]); end
    n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL write_early_ack: got %b expected 0", ack_o); end
    vack[1] = 1'b1;
    step();                                   // cycle 2
    n_checks++; if (ack_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL write_ack: got ack %b err %b expected 1/0", ack_o, err_o); end
    vack = '0; drop();
    step();
    n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL write_ack_pulse: got %b expected 0", ack_o); end
  endtask

  task automatic test_unmapped();
    req(12'h1C0, 1'b0, 32'h0);
    step();                                   // cycle 1
    n_checks++; if (vstb !== 6'b0 || vcyc !== 6'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL unmap_c1: stb %b cyc %b err %b expected 0/0/0", vstb, vcyc, err_o); end
    step();                                   // cycle 2
    n_checks++; if (err_o !== 1'b1 || ack_o !== 1'b0 || vstb !== 6'b0) begin n_fail++; $display("FAIL unmap_err: err %b ack %b stb %b expected 1/0/0", err_o, ack_o, vstb); end
    drop();
    step();
    n_checks++; if (err_o !== 1'b0 || vstb !== 6'b0) begin n_fail++; $display("FAIL unmap_after: err %b stb %b expected 0/0", err_o, vstb); end
  endtask

  task automatic test_ignore_other();
    req(12'h100, 1'b0, 32'h0);
    step();                                   // cycle 1
    n_checks++; if (vstb !== 6'b010000) begin n_fail++; $display("FAIL sel4_stb: got %b expected 010000", vstb); end
    vack[2] = 1'b1;
    step();                                   // cycle 2
    n_checks++; if (ack_o !== 1'b0 || vstb !== 6'b010000) begin n_fail++; $display("FAIL stray_ack: ack %b stb %b expected 0/010000", ack_o, vstb); end
    vack = '0; vack[4] = 1'b1; vdat_i[4*DW +: DW] = 32'hA5A50004;
    step();                                   // cycle 3
    n_checks++; if (ack_o !== 1'b1 || dat_o !== 32'hA5A50004) begin n_fail++; $display("FAIL sel4_ack: ack %b dat %h expected 1/a5a50004", ack_o, dat_o); end
    vack = '0; drop();
    step();
    req(12'h100, 1'b0, 32'h0);
    step();                                   // cycle 1
    vack[4] = 1'b1; verr[4] = 1'b1; vdat_i[4*DW +: DW] = 32'h0BAD0004;
    step();                                   // cycle 2
    n_checks++; if (err_o !== 1'b1 || ack_o !== 1'b0) begin n_fail++; $display("FAIL ackerr_prio: err %b ack %b expected 1/0", err_o, ack_o); end
    n_checks++; if (dat_o !== 32'h0BAD0004) begin n_fail++; $display("FAIL ackerr_dat: got %h expected 0bad0004", dat_o); end
    vack = '0; verr = '0; drop();
    step();
  endtask

  task automatic test_abort();
    req(12'h0C0, 1'b0, 32'h0);
    step(); step(); step();                   // cycles 1..3 in ACTIVE
    n_checks++; if (vstb !== 6'b001000) begin n_fail++; $display("FAIL abort_pre: got %b expected 001000", vstb); end
    drop();
    step();                                   // cycle 4
    n_checks++; if (vstb !== 6'b0 || vcyc !== 6'b0) begin n_fail++; $display("FAIL abort_drop: stb %b cyc %b expected 0/0", vstb, vcyc); end
    n_checks++; if (ack_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL abort_resp4: ack %b err %b expected 0/0", ack_o, err_o); end
    step();
    n_checks++; if (ack_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL abort_resp5: ack %b err %b expected 0/0", ack_o, err_o); end
    req(12'h040, 1'b1, 32'hCAFE0001);
    step();
    n_checks++; if (vstb !== 6'b000010) begin n_fail++; $display("FAIL abort_next_stb: got %b expected 000010", vstb); end
    vack[1] = 1'b1; vdat_i[1*DW +: DW] = 32'h00001111;
    step();
    n_checks++; if (ack_o !== 1'b1 || dat_o !== 32'h00001111) begin n_fail++; $display("FAIL abort_next_ack: ack %b dat %h expected 1/00001111", ack_o, dat_o); end
    vack = '0; drop();
    step();
  endtask

  task automatic test_reset_mid();
    req(12'h140, 1'b1, 32'h55AA55AA);
    step(); step(); step();                   // cycles 1..3 in ACTIVE
    n_checks++; if (vstb !== 6'b100000) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 100000", vstb); end
    rst = 1'b1; drop();
    step();
    n_checks++; if ({vcyc, vstb, vwe} !== '0 || {ack_o, err_o} !== 2'b00) begin n_fail++; $display("FAIL rstmid_ctl: got %h/%b expected 0", {vcyc, vstb, vwe}, {ack_o, err_o}); end
    n_checks++; if (dat_o !== 32'h0 || {vadr, vdat_o, vsel} !== '0) begin n_fail++; $display("FAIL rstmid_bus: dat %h expected 0 and buses 0", dat_o); end
    rst = 1'b0;
    step();
    req(12'h080, 1'b0, 32'h0);
    step();
    n_checks++; if (vstb !== 6'b000100) begin n_fail++; $display("FAIL rstmid_next_stb: got %b expected 000100", vstb); end
    vack[2] = 1'b1; vdat_i[2*DW +: DW] = 32'h00000022;
    step();
    n_checks++; if (ack_o !== 1'b1 || dat_o !== 32'h00000022) begin n_fail++; $display("FAIL rstmid_next_ack: ack %b dat %h expected 1/00000022", ack_o, dat_o); end
    vack = '0; drop();
    step();
  endtask

  initial begin
    test_reset();
    test_read_port3();
    test_timeout();
    test_write();
    test_unmapped();
    test_ignore_other();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
